// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port (IF / LD) arbiter and access sequencer for the shared
// instruction ROM. Serialises requests onto the single ROM read port, rejects
// out-of-window addresses without touching the ROM, and returns the word with
// a one-cycle acknowledge to the winner.
// Optional feature: define ROM_ARB_RR_EN for round-robin tie-breaking;
// otherwise LD has fixed priority on ties.
// All outputs come straight from flops loaded with the next-state view, so
// they follow the FSM cycle-for-cycle and clear asynchronously on reset.
`default_nettype none

module rom_arbiter #(
  parameter logic [31:0] ROM_ORIGIN = 32'h0000_0000,
  parameter logic [31:0] ROM_LENGTH = 32'h0000_0400
) (
  input  logic        iARB_CLK,
  input  logic        iARB_RSTn,
  input  logic        iIF_REQ,
  input  logic [31:0] iIF_ADDR,
  output logic        oIF_ACK,
  output logic [31:0] oIF_DATA,
  output logic        oIF_ERR,
  input  logic        iLD_REQ,
  input  logic [31:0] iLD_ADDR,
  output logic        oLD_ACK,
  output logic [31:0] oLD_DATA,
  output logic        oLD_ERR,
  output logic        oROM_CE,
  output logic        oROM_RD,
  output logic [31:0] oROM_ADDR,
  input  logic [31:0] iROM_DATA,
  output logic        oARB_BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_win_ld;      // 1: LD owns the current access, 0: IF
  logic [31:0] r_addr;
  logic        r_err;
  logic [31:0] r_data;

  logic        w_win_ld_nxt;
  logic [31:0] w_addr_nxt;
  logic        w_err_nxt;
  logic [31:0] w_data_nxt;
  logic        w_grant;
  logic        w_tie_ld;
  logic        w_pick_ld;
  logic [31:0] w_pick_addr;
  logic        w_pick_in_win;
  logic [32:0] w_pick_addr33;
  logic [32:0] w_win_lo;
  logic [32:0] w_win_hi;

  logic        r_rom_ce;
  logic        r_rom_rd;
  logic [31:0] r_rom_addr;
  logic        r_if_ack;
  logic [31:0] r_if_data;
  logic        r_if_err;
  logic        r_ld_ack;
  logic [31:0] r_ld_data;
  logic        r_ld_err;
  logic        r_busy;

  // Window bounds widened to 33 bits so ORIGIN+LENGTH cannot wrap to a false hit.
  assign w_win_lo = {1'b0, ROM_ORIGIN};
  assign w_win_hi = {1'b0, ROM_ORIGIN} + {1'b0, ROM_LENGTH};

`ifdef ROM_ARB_RR_EN
  logic r_rr_last_ld;   // 1: LD was served last, so IF wins the next tie

  // Round-robin pointer: remembers the last granted port; moves only on grant.
  always_ff @(posedge iARB_CLK or negedge iARB_RSTn) begin
    if (!iARB_RSTn) begin
      r_rr_last_ld <= 1'b1;
    end else if (w_grant) begin
      r_rr_last_ld <= w_pick_ld;
    end
  end

  assign w_tie_ld = ~r_rr_last_ld;
`else
  assign w_tie_ld = 1'b1;
`endif

  // Candidate winner and its window check, evaluated every cycle for IDLE use.
  always_comb begin
    if (iIF_REQ && iLD_REQ) begin
      w_pick_ld = w_tie_ld;
    end else if (iLD_REQ) begin
      w_pick_ld = 1'b1;
    end else begin
      w_pick_ld = 1'b0;
    end
    w_pick_addr   = w_pick_ld ? iLD_ADDR : iIF_ADDR;
    w_pick_addr33 = {1'b0, w_pick_addr};
    w_pick_in_win = (w_pick_addr33 >= w_win_lo) && (w_pick_addr33 < w_win_hi);
  end

  // Next-state and next access-context logic for the IDLE/READ/RESP sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_win_ld_nxt = r_win_ld;
    w_addr_nxt   = r_addr;
    w_err_nxt    = r_err;
    w_data_nxt   = r_data;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iIF_REQ || iLD_REQ) begin
          w_grant      = 1'b1;
          w_win_ld_nxt = w_pick_ld;
          w_addr_nxt   = w_pick_addr;
          w_data_nxt   = 32'h0000_0000;
          if (w_pick_in_win) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_READ;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        w_data_nxt  = iROM_DATA;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and latched access context.
  always_ff @(posedge iARB_CLK or negedge iARB_RSTn) begin
    if (!iARB_RSTn) begin
      r_state  <= ST_IDLE;
      r_win_ld <= 1'b0;
      r_addr   <= 32'h0000_0000;
      r_err    <= 1'b0;
      r_data   <= 32'h0000_0000;
    end else begin
      r_state  <= w_state_nxt;
      r_win_ld <= w_win_ld_nxt;
      r_addr   <= w_addr_nxt;
      r_err    <= w_err_nxt;
      r_data   <= w_data_nxt;
    end
  end

  // Registered outputs, loaded from the next-state view so they line up with the state.
  always_ff @(posedge iARB_CLK or negedge iARB_RSTn) begin
    if (!iARB_RSTn) begin
      r_rom_ce   <= 1'b0;
      r_rom_rd   <= 1'b0;
      r_rom_addr <= 32'h0000_0000;
      r_if_ack   <= 1'b0;
      r_if_data  <= 32'h0000_0000;
      r_if_err   <= 1'b0;
      r_ld_ack   <= 1'b0;
      r_ld_data  <= 32'h0000_0000;
      r_ld_err   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rom_ce   <= (w_state_nxt == ST_READ);
      r_rom_rd   <= (w_state_nxt == ST_READ);
      r_rom_addr <= (w_state_nxt == ST_READ) ? w_addr_nxt : 32'h0000_0000;
      r_if_ack   <= (w_state_nxt == ST_RESP) && !w_win_ld_nxt;
      r_if_data  <= ((w_state_nxt == ST_RESP) && !w_win_ld_nxt) ? w_data_nxt : 32'h0000_0000;
      r_if_err   <= (w_state_nxt == ST_RESP) && !w_win_ld_nxt && w_err_nxt;
      r_ld_ack   <= (w_state_nxt == ST_RESP) && w_win_ld_nxt;
      r_ld_data  <= ((w_state_nxt == ST_RESP) && w_win_ld_nxt) ? w_data_nxt : 32'h0000_0000;
      r_ld_err   <= (w_state_nxt == ST_RESP) && w_win_ld_nxt && w_err_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign oROM_CE   = r_rom_ce;
  assign oROM_RD   = r_rom_rd;
  assign oROM_ADDR = r_rom_addr;
  assign oIF_ACK   = r_if_ack;
  assign oIF_DATA  = r_if_data;
  assign oIF_ERR   = r_if_err;
  assign oLD_ACK   = r_ld_ack;
  assign oLD_DATA  = r_ld_data;
  assign oLD_ERR   = r_ld_err;
  assign oARB_BUSY = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter. The ROM is modelled as a combinational
// lookup; expected grant order depends on whether ROM_ARB_RR_EN is defined.
module tb_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic        if_err;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_ack;
  logic [31:0] ld_data;
  logic        ld_err;
  logic        rom_ce;
  logic        rom_rd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        busy;

  int checks;
  int failures;

  rom_arbiter dut (
    .iARB_CLK  (clk),
    .iARB_RSTn (rst_n),
    .iIF_REQ   (if_req),
    .iIF_ADDR  (if_addr),
    .oIF_ACK   (if_ack),
    .oIF_DATA  (if_data),
    .oIF_ERR   (if_err),
    .iLD_REQ   (ld_req),
    .iLD_ADDR  (ld_addr),
    .oLD_ACK   (ld_ack),
    .oLD_DATA  (ld_data),
    .oLD_ERR   (ld_err),
    .oROM_CE   (rom_ce),
    .oROM_RD   (rom_rd),
    .oROM_ADDR (rom_addr),
    .iROM_DATA (rom_data),
    .oARB_BUSY (busy)
  );

  // ROM content: one magic word at 0x10, otherwise a tag OR'd with the address.
  assign rom_data = (rom_addr == 32'h0000_0010) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ifack"}, {31'd0, if_ack}, 32'd0);
    chk({tag, "_ldack"}, {31'd0, ld_ack}, 32'd0);
    chk({tag, "_ce"}, {31'd0, rom_ce}, 32'd0);
  endtask

  // In-window access: READ cycle, RESP cycle, back to IDLE.
  task automatic grant(input string tag, input logic exp_ld, input logic [31:0] exp_addr,
                       input logic [31:0] exp_data);
    tick();
    chk({tag, "_rd_ce"}, {31'd0, rom_ce}, 32'd1);
    chk({tag, "_rd_rd"}, {31'd0, rom_rd}, 32'd1);
    chk({tag, "_rd_addr"}, rom_addr, exp_addr);
    chk({tag, "_rd_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_rd_acks"}, {30'd0, if_ack, ld_ack}, 32'd0);
    tick();
    chk({tag, "_rs_ce"}, {31'd0, rom_ce}, 32'd0);
    chk({tag, "_rs_ifack"}, {31'd0, if_ack}, {31'd0, ~exp_ld});
    chk({tag, "_rs_ldack"}, {31'd0, ld_ack}, {31'd0, exp_ld});
    chk({tag, "_rs_ifdata"}, if_data, exp_ld ? 32'd0 : exp_data);
    chk({tag, "_rs_lddata"}, ld_data, exp_ld ? exp_data : 32'd0);
    chk({tag, "_rs_errs"}, {30'd0, if_err, ld_err}, 32'd0);
    tick();
    chk_idle({tag, "_idle"});
  endtask

  // Rejected LD access: straight to RESP with ERR, no ROM strobe.
  task automatic reject_ld(input string tag);
    tick();
    chk({tag, "_ce"}, {31'd0, rom_ce}, 32'd0);
    chk({tag, "_rd"}, {31'd0, rom_rd}, 32'd0);
    chk({tag, "_addr"}, rom_addr, 32'd0);
    chk({tag, "_ldack"}, {31'd0, ld_ack}, 32'd1);
    chk({tag, "_lderr"}, {31'd0, ld_err}, 32'd1);
    chk({tag, "_lddata"}, ld_data, 32'd0);
    chk({tag, "_ifack"}, {31'd0, if_ack}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    tick();
    chk_idle({tag, "_idle"});
  endtask

  initial begin
    logic rr;
`ifdef ROM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    if_req   = 1'b1;
    if_addr  = 32'h0000_0000;
    ld_req   = 1'b1;
    ld_addr  = 32'h0000_0004;
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    // Reset with both requests pending: everything quiet.
    chk("rst_ce", {31'd0, rom_ce}, 32'd0);
    chk("rst_rd", {31'd0, rom_rd}, 32'd0);
    chk("rst_addr", rom_addr, 32'd0);
    chk("rst_acks", {30'd0, if_ack, ld_ack}, 32'd0);
    chk("rst_data", if_data | ld_data, 32'd0);
    chk("rst_errs", {30'd0, if_err, ld_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Continuous contention: RR alternates IF/LD, fixed priority stays on LD.
    grant("cont0", rr ? 1'b0 : 1'b1, rr ? 32'h0 : 32'h4, rr ? 32'hC0DE_0000 : 32'hC0DE_0004);
    grant("cont1", 1'b1, 32'h4, 32'hC0DE_0004);
    grant("cont2", rr ? 1'b0 : 1'b1, rr ? 32'h0 : 32'h4, rr ? 32'hC0DE_0000 : 32'hC0DE_0004);
    grant("cont3", 1'b1, 32'h4, 32'hC0DE_0004);
    // LD drops: IF finally served.
    ld_req = 1'b0;
    grant("ifafter", 1'b0, 32'h0, 32'hC0DE_0000);
    if_req = 1'b0;
    tick();
    chk_idle("noreq");

    // IF alone at 0x10.
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    grant("if10", 1'b0, 32'h10, 32'hDEAD_BEEF);
    if_req = 1'b0;

    // LD out of window: exactly at the end, and near the top of address space.
    ld_req  = 1'b1;
    ld_addr = 32'h0000_0400;
    reject_ld("ld400");
    ld_addr = 32'hFFFF_FFFC;
    reject_ld("ldtop");
    // Last in-window word.
    ld_addr = 32'h0000_03FC;
    grant("ld3fc", 1'b1, 32'h3FC, 32'hC0DE_03FC);
    ld_req = 1'b0;
    tick();

    // Reset pulsed during READ.
    if_req  = 1'b1;
    if_addr = 32'h0000_0000;
    ld_req  = 1'b1;
    ld_addr = 32'h0000_0004;
    tick();
    chk("mid_ce_pre", {31'd0, rom_ce}, 32'd1);
    chk("mid_addr_pre", rom_addr, rr ? 32'h0 : 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ce", {31'd0, rom_ce}, 32'd0);
    chk("mid_rd", {31'd0, rom_rd}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("mid_acks", {30'd0, if_ack, ld_ack}, 32'd0);
    rst_n = 1'b1;
    grant("post_rst", rr ? 1'b0 : 1'b1, rr ? 32'h0 : 32'h4, rr ? 32'hC0DE_0000 : 32'hC0DE_0004);
    if_req = 1'b0;
    ld_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and access sequencer for the shared instruction ROM. It serialises read requests from the instruction-fetch (IF) port and the data-load (LD) port onto the single ROM read port and drives the ROM chip-enable, read-enable and address. It registers the returned word and hands it back to the winning requester with a one-cycle acknowledge. Addresses outside the ROM window are rejected with an error response and never reach the ROM.

## Interface
Parameters:
- ROM_ORIGIN, 32'h0, byte base address of the ROM window
- ROM_LENGTH, 32'h400, byte length of the ROM window

Ports:
- iARB_CLK  in  1  clock; all state updates on rising edge
- iARB_RSTn  in  1  reset, asynchronous, active-low
- iIF_REQ  in  1  IF read request; held high until oIF_ACK
- iIF_ADDR  in  32  IF byte address; stable while iIF_REQ high
- oIF_ACK  out  1  one-cycle response strobe to IF
- oIF_DATA  out  32  read word; valid only while oIF_ACK high, else 0
- oIF_ERR  out  1  high with oIF_ACK when the address was out of window
- iLD_REQ, iLD_ADDR, oLD_ACK, oLD_DATA, oLD_ERR: same as IF, for the LD port
- oROM_CE  out  1  ROM chip enable
- oROM_RD  out  1  ROM read enable
- oROM_ADDR  out  32  byte address to ROM
- iROM_DATA  in  32  ROM read data, combinational from oROM_ADDR
- oARB_BUSY  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, READ, RESP.
- IDLE: if neither request is high, stay. Otherwise pick a winner (see arbitration), latch the winner id and its address. If the address is in window (ROM_ORIGIN <= addr < ROM_ORIGIN+ROM_LENGTH, compared in 33 bits so no overflow wrap), go to READ. Otherwise set the error flag, latch data 0 and go straight to RESP.
- READ: drive oROM_CE=1, oROM_RD=1, oROM_ADDR=latched address. Capture iROM_DATA at the clock edge, then go to RESP.
- RESP: assert the winner's ACK for exactly one cycle, with DATA=latched word, and ERR set if the access was rejected. The other port's ACK/DATA/ERR stay 0. Then go to IDLE unconditionally.
- Address bits [1:0] are passed through unchanged. The ROM performs word selection.
- Arbitration: when only one request is high, that port wins. When both are high, the winner follows the configured policy (see Configuration).
- A requester that keeps REQ high after its ACK is treated as a new request in the next IDLE cycle.
- Requests that arrive during READ or RESP wait. No request is dropped. REQ deasserted before ACK is a protocol violation, and its behaviour is undefined.

## Timing
- Reset state: FSM=IDLE and RR pointer=LD last-served. All outputs are 0: oROM_CE, oROM_RD, oROM_ADDR, both ACK/DATA/ERR, and oARB_BUSY.
- In-window access: REQ sampled high in IDLE at edge N, READ during cycle N+1, ACK during cycle N+2. Latency is 2 cycles from the sampling edge.
- Out-of-window access: IDLE at edge N, ACK with ERR=1 during cycle N+1, with no ROM strobe.
- Throughput: one in-window access per 3 cycles, or one rejected access per 2 cycles.
- oROM_CE/oROM_RD are high only during READ, for exactly one cycle per access.
- Reset asserted mid-access: the FSM returns to IDLE immediately and all outputs go to 0, including any in-flight ACK. Pending requests are re-arbitrated after reset release.

## Configuration
- ROM_ARB_RR_EN defined: round-robin on contention. The port that did not win the last granted access wins. After reset, IF wins the first tie. The pointer updates only on grant.
- ROM_ARB_RR_EN undefined: fixed priority, with LD always winning ties. The pointer logic is not built.

## Test plan
- Reset with both REQ high and iARB_RSTn=0: all outputs 0. After release, exactly one ROM read occurs every 3 cycles.
- IF alone, addr 0x10, ROM returns 0xDEADBEEF: oROM_ADDR=0x10 with CE=RD=1 for one cycle, then oIF_ACK=1, oIF_DATA=0xDEADBEEF, oIF_ERR=0. oLD_ACK stays 0.
- LD addr 0x400 with defaults: no oROM_CE. oLD_ACK=1, oLD_ERR=1, oLD_DATA=0, one cycle after sampling. Repeat with 0xFFFFFFFC: same result, with no wrap false-hit.
- Both REQ high continuously at 0x0/0x4, with ROM_ARB_RR_EN defined: grants go IF, LD, IF, LD, and the ACK of each grant is followed by the next grant's READ 2 cycles later.
- Same stimulus with ROM_ARB_RR_EN undefined: all grants go to LD while iLD_REQ stays high. IF is granted only after iLD_REQ drops.
- iARB_RSTn pulsed low during READ: oROM_CE, oROM_RD and oARB_BUSY drop asynchronously, no ACK is issued, and arbitration restarts with IF winning the tie.
